// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg
//   Shared definitions for the ALU execute stage: ALU_* operation codes,
//   FSM state encodings, shift-kind encoding and small decode helpers.
//   Imported by alu_exec_unit and alu_shifter.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shift_kind_t;

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

  function automatic shift_kind_t shift_kind(input logic [3:0] sel);
    shift_kind_t k;
    case (sel)
      ALU_SRL: k = SH_SRL;
      ALU_SRA: k = SH_SRA;
      default: k = SH_SLL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter
//   Shift engine for the ALU execute stage.
//   Build option: ALU_FAST_SHIFT_EN
//     defined   : combinational barrel shifter; result_o valid in the load cycle,
//                 done_o mirrors load_i.
//     undefined : iterative shifter, one bit per step; done_o pulses on the step
//                 that produces the final value, which is presented on result_o.
// Ports
//   clk, rst_n    clock / async active-low reset
//   load_i        capture data_i, shamt_i, kind_i
//   step_i        advance the iterative shifter by one bit
//   kind_i        SLL / SRL / SRA
//   data_i        value to shift
//   shamt_i       shift amount
//   done_o        final value available on result_o this cycle
//   result_o      shifted value
module alu_shifter
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     step_i,
  input  shift_kind_t              kind_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [$clog2(XLEN)-1:0]  shamt_i,
  output logic                     done_o,
  output logic [XLEN-1:0]          result_o
);

  localparam int SHW = $clog2(XLEN);

`ifdef ALU_FAST_SHIFT_EN

  logic unused_iter;
  assign unused_iter = ^{clk, rst_n, step_i};

  always_comb begin
    result_o = data_i;
    case (kind_i)
      SH_SLL:  result_o = data_i << shamt_i;
      SH_SRL:  result_o = data_i >> shamt_i;
      SH_SRA:  result_o = XLEN'($signed(data_i) >>> shamt_i);
      default: result_o = data_i;
    endcase
  end

  assign done_o = load_i;

`else

  logic [XLEN-1:0] data_q, data_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  shift_kind_t     kind_q, kind_d;
  logic [XLEN-1:0] step_val;

  // One-bit shift of the held value; SRA replicates the sign bit.
  always_comb begin
    step_val = data_q;
    case (kind_q)
      SH_SLL:  step_val = {data_q[XLEN-2:0], 1'b0};
      SH_SRL:  step_val = {1'b0, data_q[XLEN-1:1]};
      SH_SRA:  step_val = {data_q[XLEN-1], data_q[XLEN-1:1]};
      default: step_val = data_q;
    endcase
  end

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    if (load_i) begin
      data_d = data_i;
      cnt_d  = shamt_i;
      kind_d = kind_i;
    end else if (step_i && (cnt_q != '0)) begin
      data_d = step_val;
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      kind_q <= SH_SLL;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end

  // The last step's value is handed out directly so the caller can register
  // it on the same edge the shifter finishes.
  assign done_o   = step_i && (cnt_q == SHW'(1));
  assign result_o = step_val;

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute stage: takes a 4-bit ALU select plus operands over a valid/ready
//   handshake and returns a registered result with zero/carry/overflow/sign
//   flags and an illegal-op indication. Logic/arith ops take one cycle; shifts
//   take one cycle per bit unless the barrel shifter is built in.
//   Build option: ALU_FAST_SHIFT_EN (barrel shifter, SHIFT state unused).
// Ports
//   clk, rst_n          clock / async active-low reset
//   in_valid, in_ready  input handshake for alu_sel/op_a/op_b
//   alu_sel             ALU_* operation code
//   op_a, op_b          operands; op_b low $clog2(XLEN) bits are the shift amount
//   out_valid,out_ready output handshake
//   result              operation result
//   zf, cf, vf, sf      zero, carry, overflow, sign flags of result
//   illegal             alu_sel was not a defined code
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no result held, ready for a new op
// ST_SHIFT | iterative shift in progress, input stalled, no output
// ST_HOLD  | result/flags valid, held until the consumer takes them
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            cf,
  output logic            vf,
  output logic            sf,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zf_q, zf_d, cf_q, cf_d, vf_q, vf_d, sf_q, sf_d, ill_q, ill_d;

  logic            accept;
  logic            op_is_shift;
  logic [SHW-1:0]  shamt;
  logic            shift_iter;
  logic            sh_done;
  logic [XLEN-1:0] sh_result;
  logic [XLEN-1:0] imm_shift_res;

  logic [XLEN-1:0] b_eff;
  logic            cin;
  logic [XLEN:0]   sum_w;
  logic            add_cf, add_vf;
  logic [XLEN-1:0] alu_res;
  logic            alu_cf, alu_vf, alu_ill;

  logic            cap_en;
  logic [XLEN-1:0] cap_res;
  logic            cap_cf, cap_vf, cap_ill;

  assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign accept      = in_valid && in_ready;
  assign op_is_shift = is_shift(alu_sel);
  assign shamt       = op_b[SHW-1:0];

`ifdef ALU_FAST_SHIFT_EN
  assign shift_iter    = 1'b0;
  assign imm_shift_res = sh_result;
`else
  // Zero-length shifts bypass the SHIFT state and complete like any other op.
  assign shift_iter    = (shamt != '0);
  assign imm_shift_res = op_a;
`endif

  alu_shifter #(
    .XLEN(XLEN)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept && op_is_shift),
    .step_i   (state_q == ST_SHIFT),
    .kind_i   (shift_kind(alu_sel)),
    .data_i   (op_a),
    .shamt_i  (shamt),
    .done_o   (sh_done),
    .result_o (sh_result)
  );

  // Single adder serves ADD and the compare/subtract ops (a + ~b + 1).
  always_comb begin
    b_eff = op_b;
    cin   = 1'b0;
    if ((alu_sel == ALU_SUB) || (alu_sel == ALU_SLT) || (alu_sel == ALU_SLTU)) begin
      b_eff = ~op_b;
      cin   = 1'b1;
    end
    sum_w  = {1'b0, op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, cin};
    add_cf = sum_w[XLEN];
    add_vf = (op_a[XLEN-1] == b_eff[XLEN-1]) && (sum_w[XLEN-1] != op_a[XLEN-1]);
  end

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    alu_ill = 1'b0;
    case (alu_sel)
      ALU_ADD, ALU_SUB: begin
        alu_res = sum_w[XLEN-1:0];
        alu_cf  = add_cf;
        alu_vf  = add_vf;
      end
      ALU_SLT: begin
        alu_res = {{(XLEN-1){1'b0}}, sum_w[XLEN-1] ^ add_vf};
        alu_cf  = add_cf;
        alu_vf  = add_vf;
      end
      ALU_SLTU: begin
        // No carry out of a + ~b + 1 means a borrow, i.e. a < b unsigned.
        alu_res = {{(XLEN-1){1'b0}}, ~add_cf};
        alu_cf  = add_cf;
        alu_vf  = add_vf;
      end
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = imm_shift_res;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    cap_res = alu_res;
    cap_cf  = alu_cf;
    cap_vf  = alu_vf;
    cap_ill = alu_ill;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (op_is_shift && shift_iter) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_HOLD;
            cap_en  = 1'b1;
          end
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          state_d = ST_HOLD;
          cap_en  = 1'b1;
          cap_res = sh_result;
          cap_cf  = 1'b0;
          cap_vf  = 1'b0;
          cap_ill = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    vf_d     = vf_q;
    sf_d     = sf_q;
    ill_d    = ill_q;
    if (cap_en) begin
      result_d = cap_res;
      zf_d     = (cap_res == '0);
      cf_d     = cap_cf;
      vf_d     = cap_vf;
      sf_d     = cap_res[XLEN-1];
      ill_d    = cap_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      vf_q     <= 1'b0;
      sf_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      vf_q     <= vf_d;
      sf_q     <= sf_d;
      ill_q    <= ill_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign vf        = vf_q;
  assign sf        = sf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_sel = 4'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zf, cf, vf, sf, illegal;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zf        (zf),
    .cf        (cf),
    .vf        (vf),
    .sf        (sf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zf, cf, vf, sf, ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  bit   force_ready = 1'b1;
  bit   head_seen = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic on the operand values.
  function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s, lim;
    logic [32:0] wide;
    int     sh;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = 64'sh7FFFFFFF;
    sh  = int'(b % 32);
    e.res = 32'd0; e.cf = 1'b0; e.vf = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc = 0;
    case (sel)
      OP_ADD: begin
        e.res = a + b;
        wide  = {1'b0, a} + {1'b0, b};
        e.cf  = wide[32];
        s     = sa + sb;
        e.vf  = (s > lim) || (s < -lim - 1);
      end
      OP_SUB, OP_SLT, OP_SLTU: begin
        e.cf = (a >= b);
        s    = sa - sb;
        e.vf = (s > lim) || (s < -lim - 1);
        if (sel == OP_SUB)      e.res = a - b;
        else if (sel == OP_SLT) e.res = (sa < sb) ? 32'd1 : 32'd0;
        else                    e.res = (a < b) ? 32'd1 : 32'd0;
      end
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: begin
        if (sel == OP_SLL)      e.res = a << sh;
        else if (sel == OP_SRL) e.res = a >> sh;
        else                    e.res = $signed(a) >>> sh;
        e.lat = FAST ? 1 : 1 + sh;
      end
      default: e.ill = 1'b1;
    endcase
    e.zf = (e.res == 32'd0);
    e.sf = e.res[31];
    return e;
  endfunction

  // Call at posedge+#1/#2; returns at posedge+#1 after the accepting edge.
  task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b, output int waits);
    exp_t e;
    in_valid = 1'b1; alu_sel = sel; op_a = a; op_b = b; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout actual=no_accept expected=accept sel=%0h", sel);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      e = model(sel, a, b);
      e.acc = cyc;
      q.push_back(e);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    force_ready = 1'b1;
    rand_ready  = 1'b0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", q.size());
      q.delete();
    end
    @(posedge clk); #2;
  endtask

  // Monitor: compares whatever the DUT presents against the queue head.
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        head_seen = 1'b0;
        continue;
      end
      if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
      end else begin
        h = q[0];
        if (out_valid) begin
          if (!head_seen) begin
            chk("latency", 64'(cyc - h.acc + 1), 64'(h.lat));
            head_seen = 1'b1;
          end
          chk("out_fields", {27'd0, result, zf, cf, vf, sf, illegal},
              {27'd0, h.res, h.zf, h.cf, h.vf, h.sf, h.ill});
          chk("in_ready_hold", 64'(in_ready), 64'(out_ready));
          if (out_ready) begin
            void'(q.pop_front());
            head_seen = 1'b0;
          end
        end else begin
          chk("in_ready_shift", 64'(in_ready), 64'd0);
          if (cyc - h.acc > 40) begin
            checks++; failures++;
            $display("FAIL result_timeout actual=no_out_valid expected=lat_%0d", h.lat);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [31:0] pool [6];
    logic [3:0]  ops [10];
    logic [3:0]  s;
    logic [31:0] a, b;
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h7FFFFFFF;
    pool[3] = 32'h80000000; pool[4] = 32'hFFFFFFFF; pool[5] = 32'h5;
    ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_XOR; ops[4] = OP_SLL;
    ops[5] = OP_SRL; ops[6] = OP_SUB; ops[7] = OP_SLT; ops[8] = OP_SLTU; ops[9] = OP_SRA;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {out_valid, result, zf, cf, vf, sf, illegal, in_ready},
        {1'b0, 32'h0, 5'b0, 1'b1});
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    issue(OP_ADD, 32'h7FFFFFFF, 32'h1, w);
    drain();

    force_ready = 1'b0;
    @(posedge clk); #2;
    issue(OP_SUB, 32'd5, 32'd5, w);
    repeat (3) @(posedge clk);
    #2;
    drain();

    issue(OP_SRA, 32'h80000000, 32'd31, w);
    drain();

    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, w);
    chk("stream_accept_0", 64'(w), 64'd0);
    issue(OP_OR, 32'h0000_0001, 32'h0000_0000, w);
    chk("stream_accept_1", 64'(w), 64'd0);
    issue(OP_SLT, 32'hFFFFFFFF, 32'd1, w);
    chk("stream_accept_2", 64'(w), 64'd0);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'd1, w);
    chk("stream_accept_3", 64'(w), 64'd0);
    drain();

    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, w);
    drain();
    issue(OP_SLL, 32'h0000_0003, 32'h0000_0021, w);
    drain();

    issue(OP_SLL, 32'd1, 32'd20, w);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_shift_reset", {out_valid, result, zf, cf, vf, sf, illegal, in_ready},
        {1'b0, 32'h0, 5'b0, 1'b1});
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {out_valid, result, in_ready}, {1'b0, 32'h0, 1'b1});
    @(posedge clk); #2;

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      s = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 9)];
      a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      issue(s, a, b, w);
    end
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
